// File: rtl/tag_pkg.sv
// rtl/tag_pkg.sv - shared state encoding and width helpers for the tag generator
package tag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int sh_w(input int blk_w);
    return $clog2(blk_w);
  endfunction

  // Each block owns one flip bit plus a rotate amount wide enough for BLK_W.
  function automatic int key_w(input int num_blk, input int blk_w);
    return num_blk * (1 + sh_w(blk_w));
  endfunction

endpackage

// File: rtl/tag_fold.sv
// rtl/tag_fold.sv - combinational keyed fold of one message word into a block
module tag_fold
  import tag_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_BLK = 4,
  localparam int BLK_W  = DATA_W / NUM_BLK,
  localparam int SH_W   = sh_w(BLK_W),
  localparam int KEY_W  = key_w(NUM_BLK, BLK_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [KEY_W-1:0]  key,
  output logic [BLK_W-1:0]  fold
);

  logic [BLK_W-1:0]   blk;
  logic [SH_W-1:0]    sh;
  logic [2*BLK_W-1:0] dbl;

  // Rotating the doubled block left and keeping the top half gives rotl mod BLK_W.
  always_comb begin
    fold = '0;
    blk  = '0;
    sh   = '0;
    dbl  = '0;
    for (int i = 0; i < NUM_BLK; i++) begin
      blk  = data[i*BLK_W +: BLK_W] ^ {BLK_W{key[i*(1+SH_W)]}};
      sh   = key[i*(1+SH_W)+1 +: SH_W];
      dbl  = {blk, blk} << sh;
      fold = fold ^ dbl[2*BLK_W-1 -: BLK_W];
    end
  end

endmodule

// File: rtl/tag_gen_stream.sv
// rtl/tag_gen_stream.sv - keyed rolling tag over a beat stream with tag handoff
module tag_gen_stream
  import tag_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_BLK = 4,
  parameter int CNT_W   = 16,
  localparam int BLK_W  = DATA_W / NUM_BLK,
  localparam int KEY_W  = key_w(NUM_BLK, BLK_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [KEY_W-1:0]  key,
  output logic              tag_valid,
  input  logic              tag_ready,
  output logic [BLK_W-1:0]  tag,
  output logic [CNT_W-1:0]  tag_len
);

  state_t            state, next_state;
  logic [BLK_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [KEY_W-1:0]  key_q;

  logic              accept;
  logic              first_beat;
  logic [KEY_W-1:0]  key_use;
  logic [BLK_W-1:0]  fold;
  logic [BLK_W-1:0]  acc_prev, acc_new;
  logic [CNT_W-1:0]  cnt_prev, cnt_new;
  logic [BLK_W-1:0]  cnt_lo;

  assign accept     = in_valid && in_ready;
  assign first_beat = (state == IDLE);
  // The live key is used only for a message's opening beat; later beats see key_q.
  assign key_use    = first_beat ? key : key_q;
  assign acc_prev   = first_beat ? '0 : acc;
  assign cnt_prev   = first_beat ? '0 : cnt;
  assign acc_new    = {acc_prev[BLK_W-2:0], acc_prev[BLK_W-1]} ^ fold;
  assign cnt_new    = (cnt_prev == {CNT_W{1'b1}}) ? cnt_prev : cnt_prev + 1'b1;

  generate
    if (CNT_W >= BLK_W) begin : g_cnt_trunc
      assign cnt_lo = cnt_new[BLK_W-1:0];
    end else begin : g_cnt_ext
      assign cnt_lo = {{(BLK_W-CNT_W){1'b0}}, cnt_new};
    end
  endgenerate

  tag_fold #(
    .DATA_W (DATA_W),
    .NUM_BLK(NUM_BLK)
  ) u_fold (
    .data(in_data),
    .key (key_use),
    .fold(fold)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    unique case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) next_state = in_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (tag_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      key_q     <= '0;
      tag       <= '0;
      tag_len   <= '0;
      tag_valid <= 1'b0;
    end else if (accept) begin
      acc <= acc_new;
      cnt <= cnt_new;
      if (first_beat) key_q <= key;
      if (in_last) begin
        tag       <= acc_new ^ cnt_lo;
        tag_len   <= cnt_new;
        tag_valid <= 1'b1;
      end
    end else if (state == HOLD && tag_ready) begin
      tag_valid <= 1'b0;
    end
  end

endmodule

// File: doc/tag_gen_stream.md
TAG_GEN_STREAM -- requirements
Module: tag_gen_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the message word width.
REQ-002 The block SHALL have parameter NUM_BLK, default 4, meaning the blocks per word; DATA_W SHALL be divisible by NUM_BLK, and BLK_W = DATA_W/NUM_BLK SHALL be a power of two of at least 2.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the message beat counter width.
REQ-004 The block SHALL use derived constants SH_W = clog2(BLK_W) and KEY_W = NUM_BLK*(1+SH_W).
REQ-005 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit, reset, synchronous, active-high.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning a message beat is offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the offered beat.
REQ-009 The block SHALL have port in_data, input, DATA_W bits, the message word.
REQ-010 The block SHALL have port in_last, input, 1 bit, marking the final beat of a message.
REQ-011 The block SHALL have port key, input, KEY_W bits, the secret key; block i uses flip bit key[i*(1+SH_W)] and shift field key[i*(1+SH_W)+1 +: SH_W].
REQ-012 The block SHALL have port tag_valid, output, 1 bit, meaning the tag is available.
REQ-013 The block SHALL have port tag_ready, input, 1 bit, meaning the consumer takes the tag.
REQ-014 The block SHALL have port tag, output, BLK_W bits, the message tag.
REQ-015 The block SHALL have port tag_len, output, CNT_W bits, the message beat count, saturating.

Function
REQ-016 A beat SHALL be accepted in any cycle where in_valid && in_ready.
REQ-017 Per accepted word, fold SHALL be the XOR over i of rotl(blk_i ^ {BLK_W{flip_i}}, shift_i), with blk_i = in_data[i*BLK_W +: BLK_W] and rotation modulo BLK_W; a shift of 0 SHALL leave the block unchanged.
REQ-018 The FSM SHALL have states IDLE, ACCUM and HOLD.
REQ-019 In IDLE and ACCUM, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0.
REQ-020 On the first accepted beat in IDLE, key SHALL be latched into key_q and used for that beat and for the whole message; key changes mid-message SHALL have no effect.
REQ-021 The accumulator SHALL update on each beat as acc <= rotl(acc_prev,1) ^ fold, with acc_prev = 0 on a message's first beat.
REQ-022 The count SHALL update on each beat as cnt <= cnt_prev+1, with cnt_prev = 0 on the first beat, saturating at 2^CNT_W-1.
REQ-023 A beat without last SHALL move the FSM IDLE->ACCUM or ACCUM->ACCUM.
REQ-024 A beat with last (including a first-beat last) SHALL register tag = acc_new ^ cnt_new[BLK_W-1:0] (zero-extended if CNT_W<BLK_W) and tag_len = cnt_new, set tag_valid the next cycle (latency 1), and move to HOLD.
REQ-025 In HOLD, tag, tag_len and tag_valid SHALL stay stable until tag_ready=1.
REQ-026 When tag_ready=1 in HOLD, the next cycle SHALL have tag_valid=0 and state IDLE.
REQ-027 tag and tag_len SHALL keep their last values after handoff.
REQ-028 in_valid=0 in ACCUM SHALL leave acc, cnt and state unchanged.
REQ-029 Count saturation SHALL NOT alter accumulation.

Reset
REQ-030 reset SHALL be synchronous and active-high and SHALL take priority over all other events.
REQ-031 On reset: state IDLE, tag_valid 0, tag 0, tag_len 0, acc 0, cnt 0, key_q 0.
REQ-032 Reset mid-message SHALL discard the partial message, and no tag SHALL be produced for it.
REQ-033 The cycle after reset deasserts, in_ready SHALL be 1.

Structure
REQ-034 Package tag_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD) and the SH_W/KEY_W helper functions.
REQ-035 Sub-module tag_fold SHALL be a parametrised DATA_W/NUM_BLK combinational word fold (REQ-017), instantiated once.

Verification (DATA_W=32, NUM_BLK=4, CNT_W=16)
REQ-036 Key 0, one beat 0x01020304 with last -> tag=0x05 and tag_len=1, with tag_valid one cycle after acceptance.
REQ-037 Key with all flip bits set and shifts 0, the same beat -> tag=0x05 (even number of inversions cancel).
REQ-038 Block0 shift=1, other fields 0, beat 0x00000080 with last -> tag=0x00.
REQ-039 Key 0, beats 0x00000001 then 0x00000002 with last -> tag=0x02, tag_len=2; changing key between the beats SHALL leave the result unchanged.
REQ-040 tag_ready held 0 for 5 cycles -> tag stable and in_ready=0 throughout; release -> IDLE, and the next message is accepted.
REQ-041 Reset asserted after 3 beats, then a fresh single beat 0x01020304 with last, key 0 -> tag=0x05, tag_len=1.
